receive: RTL and testbench

RECEIVE -- requirements
Module: receive

---
 rtl/receive.sv | 125 ++++++++++++
 tb/tb_receive.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/receive.sv
// receive: 8N1 UART receiver with a 4-entry output FIFO and a stb/rdy handshake.
//   clk  - single clock, all logic on the rising edge
//   rst  - asynchronous active-low reset
//   rxd  - asynchronous serial line, idle high
//   rdy  - consumer ready; a byte is popped on an edge where stb and rdy are both 1
//   stb  - FIFO non-empty (a received byte is available)
//   dat  - oldest received byte, valid while stb is 1 (0 otherwise)
module receive #(
    parameter real BAUDRATE  = 9600.0,
    parameter real FREQUENCY = 12e6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    input  logic       rdy,
    output logic       stb,
    output logic [7:0] dat
);
    localparam int CYCLES = $rtoi(FREQUENCY / BAUDRATE);
    localparam int HALF   = CYCLES / 2;
    localparam int CW     = $clog2(CYCLES + 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [1:0]    sync_q;
    logic          rx_s;
    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    bit_q;
    logic [7:0]    shift_q;
    logic          err_q;
    logic          push_q;

    logic [7:0]    mem_q [4];
    logic [1:0]    wr_q, rd_q;
    logic [2:0]    fcnt_q, fcnt_d;
    logic          pop, wr_en;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) sync_q <= 2'b11;
        else      sync_q <= {sync_q[0], rxd};
    end

    assign rx_s = sync_q[1];

    // err_q blocks a new start after a framing error until the line returns high,
    // so a long break is not mistaken for a fresh start bit.
    // push_q is a registered one-cycle request; shift_q stays stable until the next
    // frame's first data sample, so the FIFO captures it on the following edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            err_q   <= 1'b0;
            push_q  <= 1'b0;
        end else begin
            push_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (rx_s) err_q <= 1'b0;
                    if (!rx_s && !err_q) begin
                        state_q <= START;
                        cnt_q   <= '0;
                        bit_q   <= '0;
                    end
                end
                START: begin
                    if (cnt_q == CW'(HALF - 1)) begin
                        cnt_q   <= '0;
                        state_q <= rx_s ? IDLE : DATA;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                DATA: begin
                    if (cnt_q == CW'(CYCLES - 1)) begin
                        cnt_q   <= '0;
                        shift_q <= {rx_s, shift_q[7:1]};
                        bit_q   <= bit_q + 3'd1;
                        if (bit_q == 3'd7) state_q <= STOP;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                STOP: begin
                    if (cnt_q == CW'(CYCLES - 1)) begin
                        cnt_q   <= '0;
                        state_q <= IDLE;
                        push_q  <= rx_s;
                        err_q   <= !rx_s;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign stb   = fcnt_q != 3'd0;
    assign dat   = stb ? mem_q[rd_q] : 8'h00;
    assign pop   = stb && rdy;
    // A full FIFO drops the incoming byte unless a pop frees a slot on the same edge.
    assign wr_en = push_q && (fcnt_q != 3'd4 || pop);

    always_comb begin
        fcnt_d = fcnt_q + {2'b00, wr_en} - {2'b00, pop};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) mem_q[i] <= '0;
            wr_q   <= '0;
            rd_q   <= '0;
            fcnt_q <= '0;
        end else begin
            if (wr_en) mem_q[wr_q] <= shift_q;
            wr_q   <= wr_q + {1'b0, wr_en};
            rd_q   <= rd_q + {1'b0, pop};
            fcnt_q <= fcnt_d;
        end
    end
endmodule

// File: tb/tb_receive.sv
// tb_receive: directed checks of the receive UART with a 16-clocks-per-bit setup.
module tb_receive;
    localparam real FREQ = 16e6;
    localparam real BAUD = 1e6;
    localparam int  CYC  = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rxd = 1'b1;
    logic       rdy = 1'b0;
    logic       stb;
    logic [7:0] dat;
    int         n_checks = 0;
    int         n_errors = 0;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       exp_stb;
        logic [7:0] exp_dat;
    } vec_t;

    vec_t vecs[7];

    always #5 clk = ~clk;

    receive #(.BAUDRATE(BAUD), .FREQUENCY(FREQ)) dut (
        .clk(clk), .rst(rst), .rxd(rxd), .rdy(rdy), .stb(stb), .dat(dat)
    );

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rxd = f[i];
            repeat (CYC) @(negedge clk);
        end
    endtask

    task automatic pop;
        rdy = 1'b1;
        @(negedge clk);
        rdy = 1'b0;
    endtask

    task automatic quiet(input string name, input int cycles);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            seen = seen | stb;
        end
        check(name, 8'(seen), 8'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{8'hA5, 1'b1, 1'b1, 8'hA5};
        vecs[1] = '{8'h3E, 1'b1, 1'b1, 8'h3E};
        vecs[2] = '{8'h81, 1'b1, 1'b1, 8'h81};
        vecs[3] = '{8'h7F, 1'b1, 1'b1, 8'h7F};
        vecs[4] = '{8'h00, 1'b1, 1'b1, 8'h00};
        vecs[5] = '{8'h55, 1'b0, 1'b0, 8'h00};
        vecs[6] = '{8'h12, 1'b1, 1'b1, 8'h12};

        repeat (3) begin
            @(negedge clk);
            check("reset_stb", 8'(stb), 8'd0);
            check("reset_dat", dat, 8'h00);
        end
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("post_reset_stb", 8'(stb), 8'd0);
            check("post_reset_dat", dat, 8'h00);
        end

        for (int v = 0; v < 7; v++) begin
            send(vecs[v].data, vecs[v].stop);
            if (!vecs[v].stop) begin
                repeat (CYC) @(negedge clk);
                rxd = 1'b1;
                repeat (CYC) @(negedge clk);
            end
            repeat (4) @(negedge clk);
            check($sformatf("vec%0d_stb", v), 8'(stb), 8'(vecs[v].exp_stb));
            check($sformatf("vec%0d_dat", v), dat, vecs[v].exp_dat);
            if (stb) pop;
            check($sformatf("vec%0d_stb_after_pop", v), 8'(stb), 8'd0);
        end

        send(8'h3C, 1'b1);
        check("b2b_first_stb", 8'(stb), 8'd1);
        check("b2b_first_dat", dat, 8'h3C);
        send(8'hC3, 1'b1);
        repeat (4) @(negedge clk);
        check("b2b_hold_stb", 8'(stb), 8'd1);
        check("b2b_hold_dat", dat, 8'h3C);
        pop;
        check("b2b_second_stb", 8'(stb), 8'd1);
        check("b2b_second_dat", dat, 8'hC3);
        pop;
        check("b2b_empty_stb", 8'(stb), 8'd0);

        rxd = 1'b0;
        repeat (CYC / 4) @(negedge clk);
        rxd = 1'b1;
        quiet("glitch_no_stb", 25 * CYC);

        for (int k = 1; k <= 6; k++) send(8'(k), 1'b1);
        repeat (4) @(negedge clk);
        for (int k = 1; k <= 4; k++) begin
            check($sformatf("full_stb%0d", k), 8'(stb), 8'd1);
            check($sformatf("full_dat%0d", k), dat, 8'(k));
            pop;
        end
        check("full_drained_stb", 8'(stb), 8'd0);

        send(8'h77, 1'b1);
        repeat (4) @(negedge clk);
        check("pre_abort_stb", 8'(stb), 8'd1);
        rxd = 1'b0;
        repeat (3 * CYC) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("abort_stb", 8'(stb), 8'd0);
        check("abort_dat", dat, 8'h00);
        rxd = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        quiet("abort_no_partial", 12 * CYC);
        send(8'h99, 1'b1);
        repeat (4) @(negedge clk);
        check("recover_stb", 8'(stb), 8'd1);
        check("recover_dat", dat, 8'h99);
        pop;
        check("recover_empty", 8'(stb), 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
